// File: rtl/imem_loader_if.sv
// Command, byte-stream and memory write-port bundle for the instruction memory loader.
interface imem_loader_if #(parameter int ADDR_W = 64);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [15:0]       len_i;
  logic [7:0]        csum_i;
  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [7:0]        wdata_o;
  logic              busy_o;
  logic              done_o;
  logic              range_err_o;
  logic              csum_err_o;
  logic              cpu_hold_o;

  modport slave (
    input  start_i, base_addr_i, len_i, csum_i, byte_valid_i, byte_data_i,
    output byte_ready_o, we_o, waddr_o, wdata_o, busy_o, done_o,
           range_err_o, csum_err_o, cpu_hold_o
  );

  modport master (
    output start_i, base_addr_i, len_i, csum_i, byte_valid_i, byte_data_i,
    input  byte_ready_o, we_o, waddr_o, wdata_o, busy_o, done_o,
           range_err_o, csum_err_o, cpu_hold_o
  );
endinterface

// File: rtl/imem_loader.sv
// Streams bytes into the Y86 instruction memory with range and XOR-checksum checks;
// holds fetch off until a load completes cleanly.
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERROR} state_t;

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       rem_q, rem_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        exp_q, exp_d;
  logic              rng_q, rng_d;   // distinguishes range vs checksum failure in ERROR
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [ADDR_W:0]   end_addr;
  logic              over;

  assign end_addr = {1'b0, bus.base_addr_i} + (ADDR_W+1)'(bus.len_i);
  assign over     = end_addr > MEM_LIMIT;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    exp_d   = exp_q;
    rng_d   = rng_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start_i) begin
          csum_d = 8'h00;
          exp_d  = bus.csum_i;
          addr_d = bus.base_addr_i;
          rem_d  = bus.len_i;
          rng_d  = over;
          if (over)                  state_d = S_ERROR;
          else if (bus.len_i == '0)  state_d = S_CHECK;
          else                       state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.byte_valid_i) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = bus.byte_data_i;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          csum_d  = csum_q ^ bus.byte_data_i;
          if (rem_q == 16'd1) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        rng_d   = 1'b0;
        state_d = (csum_q == exp_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      exp_q   <= '0;
      rng_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      exp_q   <= exp_d;
      rng_q   <= rng_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.byte_ready_o = (state_q == S_LOAD);
  assign bus.busy_o       = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign bus.done_o       = (state_q == S_DONE);
  assign bus.range_err_o  = (state_q == S_ERROR) && rng_q;
  assign bus.csum_err_o   = (state_q == S_ERROR) && !rng_q;
  assign bus.cpu_hold_o   = (state_q != S_DONE);
  assign bus.we_o         = we_q;
  assign bus.waddr_o      = waddr_q;
  assign bus.wdata_o      = wdata_q;

endmodule
